// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared states, ALU encodings, mux selects and RV32I opcodes for the multicycle control unit
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_JALR, S_JALWB, S_BRANCH, S_UPPER, S_TRAP
  } state_t;

  // ALU operation class handed from the FSM to the funct decoder
  typedef enum logic [2:0] {
    AOP_ADD, AOP_SUB, AOP_RTYPE, AOP_ITYPE, AOP_PASSB
  } aluop_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps FSM ALU class plus funct3/funct7b5 to an ALUControl encoding
module mc_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  aluop_t                aluop,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] op;

  always_comb begin
    op = ALU_ADD;
    case (aluop)
      AOP_ADD:   op = ALU_ADD;
      AOP_SUB:   op = ALU_SUB;
      AOP_PASSB: op = ALU_PASSB;
      AOP_RTYPE, AOP_ITYPE: begin
        case (funct3)
          // addi has no subtract form, so funct7b5 only selects SUB for R-type
          3'b000:  op = (aluop == AOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM with cache stall and stall counter
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_instr.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr,
  input  logic                   zero,
  input  logic                   lt,
  input  logic                   ltu,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   AdrSrc,
  output logic                   IRWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   RegWrite,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ImmSrc,
  output logic [ALU_CTRL_W-1:0]  ALUControl,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                   illegal_instr
`endif
);

  state_t     state, next_state;
  aluop_t     aluop;
  logic       stall_inc;
  logic       br_cond;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7b5          = instr[30];
  assign unused_instr_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .aluop       (aluop),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_inc && stall_cnt != '1)
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  always_comb begin
    case (funct3)
      3'b000:  br_cond = zero;
      3'b001:  br_cond = !zero;
      3'b100:  br_cond = lt;
      3'b101:  br_cond = !lt;
      3'b110:  br_cond = ltu;
      3'b111:  br_cond = !ltu;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ImmSrc     = IMM_I;
    aluop      = AOP_ADD;
    stall_inc  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state = S_TRAP;
`else
          default:           next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
        else           stall_inc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next_state = S_FETCH;
        else           stall_inc  = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        aluop      = (state == S_EXECI) ? AOP_ITYPE : AOP_RTYPE;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ImmSrc     = IMM_J;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = S_JALWB;
      end
      // target sits in ALUOut from JALR while the ALU forms oldPC+4 for the link
      S_JALWB: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        aluop      = AOP_SUB;
        PCWrite    = br_cond;
        next_state = S_FETCH;
      end
      S_UPPER: begin
        ImmSrc     = IMM_U;
        ALUSrcB    = SRCB_IMM;
        ALUSrcA    = (opcode == OP_AUIPC) ? SRCA_OLDPC : SRCA_PC;
        aluop      = (opcode == OP_AUIPC) ? AOP_ADD : AOP_PASSB;
        next_state = S_ALUWB;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
    if (rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ImmSrc    = IMM_I;
      aluop     = AOP_ADD;
      stall_inc = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`endif

endmodule
